// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-stage bus: instruction memory port, redirect input and the decode-side handshake.
// The fetch stage drives the master modport; memory/decode/ALU side drives the slave modport.
interface fetch_prefetch_queue_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               flush_pipeline;
    logic [PC_W-1:0]    redirect_pc;
    logic               dec_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [OCC_W-1:0]   occupancy;

    modport master (
        output imem_addr,
        input  imem_data,
        input  flush_pipeline,
        input  redirect_pc,
        input  dec_ready,
        output out_valid,
        output out_instr,
        output out_pc,
        output occupancy
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output flush_pipeline,
        output redirect_pc,
        output dec_ready,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  occupancy
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage: owns the PC, fetches one word per cycle into a small
// {pc, instr} FIFO and hands the head to decode; a flush empties the FIFO and redirects fetch.
module fetch_prefetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                    clk,
    input logic                    rst,
    fetch_prefetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PC_W-1:0]    pc;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   occ;
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic not_empty;
    logic pop;
    logic push;

    // A full queue can still accept a word in the cycle its head leaves.
    always_comb begin
        not_empty = (occ != '0);
        pop       = not_empty & bus.dec_ready;
        push      = ~bus.flush_pipeline & ((occ < OCC_W'(DEPTH)) | pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush_pipeline) begin
            pc     <= bus.redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                pc     <= pc + PC_W'(1);
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage carries no reset; empty entries are masked on the outputs instead.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]    <= pc;
            instr_mem[wr_ptr] <= bus.imem_data;
        end
    end

    always_comb begin
        bus.imem_addr = pc;
        bus.out_valid = not_empty;
        bus.out_pc    = not_empty ? pc_mem[rd_ptr]    : '0;
        bus.out_instr = not_empty ? instr_mem[rd_ptr] : '0;
        bus.occupancy = occ;
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vector table, a hand-written flush sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_prefetch_queue;
    localparam int              DEPTH    = 4;
    localparam int              PC_W     = 16;
    localparam int              INSTR_W  = 32;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [15:0] redirect;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [2:0]  exp_occ;
        logic [15:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    entry_t      model_q[$];
    logic [15:0] model_pc;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    fetch_prefetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) bus();

    fetch_prefetch_queue #(
        .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.imem_data = mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of fetched words plus a PC, advanced one clock at a time.
    task automatic model_step(input logic r, input logic f, input logic [15:0] rd, input logic dr);
        bit do_pop;
        bit do_push;
        entry_t e;
        if (r) begin
            model_q.delete();
            model_pc = RESET_PC;
        end else if (f) begin
            model_q.delete();
            model_pc = rd;
        end else begin
            do_pop  = (model_q.size() != 0) && dr;
            do_push = (model_q.size() < DEPTH) || do_pop;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc    = model_pc;
                e.instr = mem_word(model_pc);
                model_q.push_back(e);
                model_pc = model_pc + 16'd1;
            end
        end
    endtask

    task automatic check_output();
        logic [15:0] m_pc;
        logic [31:0] m_instr;
        m_pc    = (model_q.size() != 0) ? model_q[0].pc    : 16'h0;
        m_instr = (model_q.size() != 0) ? model_q[0].instr : 32'h0;
        check("model out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
        check("model occupancy", 32'(bus.occupancy), 32'(model_q.size()));
        check("model imem_addr", 32'(bus.imem_addr), 32'(model_pc));
        check("model out_pc",    32'(bus.out_pc),    32'(m_pc));
        check("model out_instr", bus.out_instr,      m_instr);
    endtask

    task automatic apply_stimulus(input logic r, input logic f, input logic [15:0] rd, input logic dr);
        rst                = r;
        bus.flush_pipeline = f;
        bus.redirect_pc    = rd;
        bus.dec_ready      = dr;
        @(posedge clk);
        model_step(r, f, rd, dr);
        @(negedge clk);
        check_output();
    endtask

    task automatic add_vec(input logic r, input logic f, input logic [15:0] rd, input logic dr,
                           input logic ev, input logic [15:0] ep, input logic [2:0] eo,
                           input logic [15:0] ea);
        vec_t v;
        v.rst = r; v.flush = f; v.redirect = rd; v.ready = dr;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_occ = eo; v.exp_addr = ea;
        vecs.push_back(v);
    endtask

    initial begin
        rst                = 1'b1;
        bus.flush_pipeline = 1'b0;
        bus.redirect_pc    = 16'h0;
        bus.dec_ready      = 1'b0;

        // Reset, then stall decode: queue fills to DEPTH and fetch stops at address 4.
        add_vec(1'b1, 1'b0, 16'h0000, 1'b0,  1'b0, 16'h0000, 3'd0, 16'h0000);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0000, 3'd1, 16'h0001);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0000, 3'd2, 16'h0002);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0000, 3'd3, 16'h0003);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0000, 3'd4, 16'h0004);
        for (int i = 0; i < 6; i++)
            add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0000, 3'd4, 16'h0004);
        // Single pop while full: occupancy stays 4, pc advances.
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0001, 3'd4, 16'h0005);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0001, 3'd4, 16'h0005);
        // Flush drops the head even with dec_ready high; refill to 3 entries.
        add_vec(1'b0, 1'b1, 16'h0020, 1'b1,  1'b0, 16'h0000, 3'd0, 16'h0020);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0020, 3'd1, 16'h0021);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0020, 3'd2, 16'h0022);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0020, 3'd3, 16'h0023);
        add_vec(1'b0, 1'b1, 16'h0009, 1'b1,  1'b0, 16'h0000, 3'd0, 16'h0009);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0009, 3'd1, 16'h000A);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0009, 3'd2, 16'h000B);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b0,  1'b1, 16'h0009, 3'd3, 16'h000C);
        // Reset beats a simultaneous flush; then a continuous stream from RESET_PC.
        add_vec(1'b1, 1'b1, 16'h0055, 1'b1,  1'b0, 16'h0000, 3'd0, 16'h0000);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0000, 3'd1, 16'h0001);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0001, 3'd1, 16'h0002);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0002, 3'd1, 16'h0003);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0003, 3'd1, 16'h0004);
        // PC wrap at the top of the address space.
        add_vec(1'b0, 1'b1, 16'hFFFE, 1'b1,  1'b0, 16'h0000, 3'd0, 16'hFFFE);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'hFFFE, 3'd1, 16'hFFFF);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'hFFFF, 3'd1, 16'h0000);
        add_vec(1'b0, 1'b0, 16'h0000, 1'b1,  1'b1, 16'h0000, 3'd1, 16'h0001);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].flush, vecs[i].redirect, vecs[i].ready);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d out_pc", i),    32'(bus.out_pc),    32'(vecs[i].exp_pc));
            check($sformatf("vec%0d occupancy", i), 32'(bus.occupancy), 32'(vecs[i].exp_occ));
            check($sformatf("vec%0d imem_addr", i), 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d out_instr", i), bus.out_instr,
                  vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0);
        end

        // Back-to-back flushes: the second target wins and the queue stays empty between them.
        apply_stimulus(1'b0, 1'b1, 16'h0003, 1'b1);
        check("b2b first flush occupancy", 32'(bus.occupancy), 32'd0);
        apply_stimulus(1'b0, 1'b1, 16'h0007, 1'b0);
        check("b2b second flush valid", 32'(bus.out_valid), 32'd0);
        check("b2b second flush addr", 32'(bus.imem_addr), 32'h0007);
        apply_stimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        check("b2b head pc", 32'(bus.out_pc), 32'h0007);
        check("b2b head occupancy", 32'(bus.occupancy), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic        f;
            logic [15:0] rd;
            logic        dr;
            r  = ($urandom_range(0, 63) == 0);
            f  = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                             : 16'($urandom);
            dr = ($urandom_range(0, 2) != 0);
            apply_stimulus(r, f, rd, dr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
